// File: rtl/inst_mem_loadable.sv
// inst_mem_loadable
//   Instruction memory for the pipelined CPU. After reset it sits in LOAD and
//   packs a little-endian byte stream into 32-bit words. A word is written
//   when its 4th byte arrives. A partial word is flushed, zero-padded, on
//   LoadDone. The block enters RUN on LoadDone or when the memory is full.
//   In RUN it serves fetches through a registered read port with one cycle
//   of latency. ReadEn=0 holds the read outputs.
//
//   Ports
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     LoadByte          program byte from the loader
//     LoadByteValid     LoadByte is valid this cycle
//     LoadDone          loader finished; flush any partial word, go to RUN
//     Loading           1 while in LOAD
//     LoadCount         number of words written during this load
//     ReadAddr          byte address of the fetch (PC)
//     ReadEn            fetch enable; 0 holds ReadInst/InstValid/AddrErr
//     ReadInst          fetched instruction (NOP_WORD when none or on error)
//     InstValid         ReadInst holds a completed fetch
//     AddrErr           last fetch was misaligned or out of range
module inst_mem_loadable #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [7:0]                           LoadByte,
    input  logic                                 LoadByteValid,
    input  logic                                 LoadDone,
    output logic                                 Loading,
    output logic [$clog2(DEPTH_WORDS+1)-1:0]     LoadCount,
    input  logic [ADDR_WIDTH-1:0]                ReadAddr,
    input  logic                                 ReadEn,
    output logic [31:0]                          ReadInst,
    output logic                                 InstValid,
    output logic                                 AddrErr
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(DEPTH_WORDS + 1);

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]  word_ptr_q, word_ptr_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       read_inst_q, read_inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic              addr_err_q, addr_err_d;

    logic [31:0]           mem [DEPTH_WORDS];
    logic                  mem_we;
    logic [31:0]           asm_merged;
    logic [ADDR_WIDTH-1:0] word_addr;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            byte_idx_q   <= '0;
            word_ptr_q   <= '0;
            asm_q        <= '0;
            read_inst_q  <= NOP_WORD;
            inst_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            word_ptr_q   <= word_ptr_d;
            asm_q        <= asm_d;
            read_inst_q  <= read_inst_d;
            inst_valid_q <= inst_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // Storage is intentionally not reset: words not overwritten by a new
    // load keep their previous contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_ptr_q[IDX_W-1:0]] <= asm_merged;
        end
    end

    // Next-state and load datapath
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_ptr_d = word_ptr_q;
        asm_d      = asm_q;
        asm_merged = asm_q;
        mem_we     = 1'b0;

        if (state_q == ST_LOAD) begin
            // The byte of this cycle is merged first so that a LoadDone in
            // the same cycle flushes a word that includes it.
            if (LoadByteValid) begin
                asm_merged[8*byte_idx_q +: 8] = LoadByte;
                byte_idx_d = byte_idx_q + 2'd1;
                asm_d      = asm_merged;
            end

            mem_we = (LoadByteValid && (byte_idx_q == 2'd3)) ||
                     (LoadDone && (LoadByteValid || (byte_idx_q != 2'd0)));

            if (mem_we) begin
                word_ptr_d = word_ptr_q + CNT_W'(1);
                byte_idx_d = 2'd0;
                asm_d      = '0;
            end

            // Writing the last slot leaves LOAD on the same edge, so the
            // pointer never reaches DEPTH_WORDS while still loading.
            if (LoadDone || (mem_we && (word_ptr_q == CNT_W'(DEPTH_WORDS - 1)))) begin
                state_d = ST_RUN;
            end
        end
    end

    // Fetch path and outputs
    always_comb begin
        word_addr    = ReadAddr >> 2;
        read_inst_d  = read_inst_q;
        inst_valid_d = inst_valid_q;
        addr_err_d   = addr_err_q;

        if ((state_q == ST_RUN) && ReadEn) begin
            inst_valid_d = 1'b1;
            if ((ReadAddr[1:0] != 2'b00) || (word_addr >= ADDR_WIDTH'(DEPTH_WORDS))) begin
                read_inst_d = NOP_WORD;
                addr_err_d  = 1'b1;
            end else begin
                read_inst_d = mem[word_addr[IDX_W-1:0]];
                addr_err_d  = 1'b0;
            end
        end

        Loading   = (state_q == ST_LOAD);
        LoadCount = word_ptr_q;
        ReadInst  = read_inst_q;
        InstValid = inst_valid_q;
        AddrErr   = addr_err_q;
    end

endmodule

// File: tb/tb_inst_mem_loadable.sv
module tb_inst_mem_loadable;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    LoadByte = '0;
    logic          LoadByteValid = 1'b0;
    logic          LoadDone = 1'b0;
    logic          Loading;
    logic [CW-1:0] LoadCount;
    logic [31:0]   ReadAddr = '0;
    logic          ReadEn = 1'b0;
    logic [31:0]   ReadInst;
    logic          InstValid;
    logic          AddrErr;

    inst_mem_loadable #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_WIDTH (32),
        .NOP_WORD   (NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .LoadByte     (LoadByte),
        .LoadByteValid(LoadByteValid),
        .LoadDone     (LoadDone),
        .Loading      (Loading),
        .LoadCount    (LoadCount),
        .ReadAddr     (ReadAddr),
        .ReadEn       (ReadEn),
        .ReadInst     (ReadInst),
        .InstValid    (InstValid),
        .AddrErr      (AddrErr)
    );

    always #5 clk = ~clk;

    // Reference model: the words the memory should hold, and which are known
    logic [31:0] model_mem [DEPTH];
    bit          known [DEPTH];
    logic [7:0]  bq [$];
    logic [31:0] last_inst;
    logic        last_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        LoadByteValid = 1'b0;
        LoadDone      = 1'b0;
        ReadEn        = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // mode 0: no LoadDone, 1: LoadDone with last byte,
    // 2: LoadDone one cycle after last byte, 3: stop mid-load (no LoadDone)
    task automatic load_stream(input int unsigned mode, input string tag);
        int unsigned acc = 0;
        int unsigned nwords;
        int unsigned waited = 0;
        for (int i = 0; i < bq.size(); i++) begin
            repeat ($urandom_range(0, 2)) tick();
            LoadByte      = bq[i];
            LoadByteValid = 1'b1;
            LoadDone      = (mode == 1) && (i == bq.size() - 1);
            tick();
            LoadByteValid = 1'b0;
            LoadDone      = 1'b0;
            if (acc < 4 * DEPTH) acc++;
        end
        if (mode == 2) begin
            LoadDone = 1'b1;
            tick();
            LoadDone = 1'b0;
        end
        nwords = (mode == 1 || mode == 2) ? (acc + 3) / 4 : acc / 4;
        for (int unsigned w = 0; w < nwords; w++) begin
            model_mem[w] = '0;
            for (int unsigned k = 0; k < 4; k++)
                if (4 * w + k < acc) model_mem[w][8*k +: 8] = bq[4*w + k];
            known[w] = 1'b1;
        end
        if (mode == 3) begin
            check({tag, "_loading"}, Loading, 1);
        end else begin
            while (Loading !== 1'b0 && waited < 8) begin
                tick();
                waited++;
            end
            check({tag, "_loading"}, Loading, 0);
        end
        check({tag, "_count"}, LoadCount, nwords);
    endtask

    task automatic fetch(input logic [31:0] addr, input string tag);
        logic        ee;
        logic [31:0] e;
        ee = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
        e  = ee ? NOP : model_mem[addr >> 2];
        ReadAddr = addr;
        ReadEn   = 1'b1;
        tick();
        ReadEn = 1'b0;
        check({tag, "_inst"}, ReadInst, e);
        check({tag, "_valid"}, InstValid, 1);
        check({tag, "_err"}, AddrErr, ee);
        last_inst = e;
        last_err  = ee;
    endtask

    task automatic hold_cycles(input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) begin
            ReadAddr = $urandom;
            ReadEn   = 1'b0;
            tick();
            check({tag, "_hinst"}, ReadInst, last_inst);
            check({tag, "_hvalid"}, InstValid, 1);
            check({tag, "_herr"}, AddrErr, last_err);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            known[i]     = 1'b0;
            model_mem[i] = '0;
        end

        // Reset state and read ignored during LOAD
        @(negedge clk);
        do_reset();
        check("rst_loading", Loading, 1);
        check("rst_count", LoadCount, 0);
        check("rst_inst", ReadInst, NOP);
        check("rst_valid", InstValid, 0);
        check("rst_err", AddrErr, 0);
        ReadAddr = 32'h0;
        ReadEn   = 1'b1;
        tick();
        ReadEn = 1'b0;
        check("load_rd_valid", InstValid, 0);
        check("load_rd_inst", ReadInst, NOP);

        // Two-word program, LoadDone with the last byte
        bq = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h01, 8'h00, 8'h09, 8'h20};
        load_stream(1, "prog");
        fetch(32'h0, "prog_w0");
        check("prog_w0_const", ReadInst, 32'h2008_0013);
        fetch(32'h4, "prog_w1");
        check("prog_w1_const", ReadInst, 32'h2009_0001);

        // Partial word flushed by LoadDone alongside its last byte
        do_reset();
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        load_stream(1, "part");
        fetch(32'h4, "part_w1");
        check("part_w1_const", ReadInst, 32'h0000_2211);
        fetch(32'h0, "part_w0");
        check("part_w0_const", ReadInst, 32'hDDCC_BBAA);

        // Overfill: 20 bytes, memory full after 16, extras ignored
        do_reset();
        bq = {};
        for (int i = 0; i < 20; i++) bq.push_back(8'($urandom));
        load_stream(0, "full");
        for (int unsigned w = 0; w < DEPTH; w++) fetch(32'(4 * w), "full_w");

        // Address errors
        fetch(32'h2, "mis");
        fetch(32'(4 * DEPTH), "oor");
        fetch(32'h0, "ok0");
        fetch(32'h5, "mis5");
        fetch(32'hFFFF_FFFC, "oor_hi");

        // Hold while ReadEn=0 and ReadAddr changes
        fetch(32'h4, "hold");
        hold_cycles(3, "hold");

        // Reset mid-load, then reload one word; other words keep stale data
        do_reset();
        bq = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        load_stream(3, "abort");
        do_reset();
        check("abort_rst_count", LoadCount, 0);
        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        load_stream(1, "reload");
        fetch(32'h0, "reload_w0");
        check("reload_w0_const", ReadInst, 32'h0403_0201);
        for (int unsigned w = 1; w < DEPTH; w++) fetch(32'(4 * w), "stale_w");

        // Randomised loads and fetches against the model
        for (int it = 0; it < 25; it++) begin
            int unsigned n;
            int unsigned mode;
            do_reset();
            n = $urandom_range(0, 20);
            bq = {};
            for (int unsigned i = 0; i < n; i++) bq.push_back(8'($urandom));
            if (n == 0) mode = 2;
            else begin
                mode = $urandom_range(0, 2);
                if (mode == 0 && n < 4 * DEPTH) mode = 1;
            end
            load_stream(mode, "rnd_load");
            for (int f = 0; f < 8; f++) begin
                int unsigned kind;
                int unsigned w;
                kind = $urandom_range(0, 3);
                w    = $urandom_range(0, DEPTH - 1);
                if (kind <= 1) begin
                    if (known[w]) fetch(32'(4 * w), "rnd_ok");
                end else if (kind == 2) begin
                    fetch(32'(4 * w + $urandom_range(1, 3)), "rnd_mis");
                end else begin
                    fetch(32'(4 * DEPTH + 4 * $urandom_range(0, 100000)), "rnd_oor");
                end
                if (InstValid === 1'b1) hold_cycles($urandom_range(0, 2), "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
